// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter for a shared WIDTH-bit 2:1 mux. It grants one of two requesters
// at a time and drives the mux select. Accepted beats are registered onto y with a
// y_valid strobe. A per-grant hold limit keeps one channel from starving the other.
module mux2_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   output logic             busy
);

   // Hold counter is at least one bit wide so MAX_HOLD=1 still elaborates cleanly.
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   // State codes double as the grant flops: bit 0 is gnt0 and bit 1 is gnt1.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   state_t           state_reg, state_next;
   logic [HW-1:0]    hold_reg, hold_next;
   logic             last_reg, last_next;   // channel granted most recently; 1 favours ch0
   logic             beat;
   logic [WIDTH-1:0] y_reg;
   logic             y_valid_reg;

   // Next-state logic: IDLE arbitration, release handover and the hold-limit forced switch.
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      last_next  = last_reg;
      beat       = 1'b0;
      case (state_reg)
         IDLE: begin
            hold_next = '0;
            if (req0 && req1) begin
               state_next = last_reg ? G0 : G1;
            end else if (req0) begin
               state_next = G0;
            end else if (req1) begin
               state_next = G1;
            end
         end
         G0: begin
            if (!req0) begin
               state_next = req1 ? G1 : IDLE;
               last_next  = 1'b0;
               hold_next  = '0;
            end else begin
               beat = 1'b1;
               if (hold_reg == HOLD_LAST) begin
                  // Saturate here until the other side asks, then hand over on that beat.
                  if (req1) begin
                     state_next = G1;
                     last_next  = 1'b0;
                     hold_next  = '0;
                  end
               end else begin
                  hold_next = hold_reg + HW'(1);
               end
            end
         end
         G1: begin
            if (!req1) begin
               state_next = req0 ? G0 : IDLE;
               last_next  = 1'b1;
               hold_next  = '0;
            end else begin
               beat = 1'b1;
               if (hold_reg == HOLD_LAST) begin
                  if (req0) begin
                     state_next = G0;
                     last_next  = 1'b1;
                     hold_next  = '0;
                  end
               end else begin
                  hold_next = hold_reg + HW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            hold_next  = '0;
         end
      endcase
   end

   // Arbitration state registers; reset favours channel 0 on the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         hold_reg  <= '0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         last_reg  <= last_next;
      end
   end

   // Output register: capture the granted input on a beat, otherwise hold y and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg       <= '0;
         y_valid_reg <= 1'b0;
      end else begin
         y_valid_reg <= beat;
         if (beat) begin
            y_reg <= state_reg[1] ? i1 : i0;
         end
      end
   end

   assign gnt0    = state_reg[0];
   assign gnt1    = state_reg[1];
   assign s       = state_reg[1];
   assign busy    = state_reg[0] | state_reg[1];
   assign y       = y_reg;
   assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
// Directed bench: default instance (WIDTH=1, MAX_HOLD=4) plus a WIDTH=8, MAX_HOLD=1
// instance. Observed outputs are packed as {gnt0,gnt1,s,busy,y_valid,y}.
module tb_mux2_rr_arbiter;

   logic clk;
   logic rst_n, req0, req1, i0, i1;
   logic gnt0, gnt1, s, y, y_valid, busy;

   logic       rst8_n, r80, r81;
   logic [7:0] a8, b8, y8;
   logic       g80, g81, s8, yv8, busy8;

   int n_cmp = 0;
   int n_err = 0;

   mux2_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .i0(i0), .i1(i1),
      .gnt0(gnt0), .gnt1(gnt1), .s(s), .y(y), .y_valid(y_valid), .busy(busy)
   );

   mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut8 (
      .clk(clk), .rst_n(rst8_n), .req0(r80), .req1(r81), .i0(a8), .i1(b8),
      .gnt0(g80), .gnt1(g81), .s(s8), .y(y8), .y_valid(yv8), .busy(busy8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] o;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; i0 = 1'b0; i1 = 1'b0;
      #2;
      o = {gnt0, gnt1, s, busy, y_valid, y};
      n_cmp++;
      if (o !== 6'b000000) begin
         n_err++;
         $display("FAIL reset_state: got %b want %b", o, 6'b000000);
      end else $display("reset_state ok %b", o);
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [5:0] o, e;
      logic [2:0] pat;
      pat = 3'b101;
      req0 = 1'b1; i0 = 1'b1;
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b100100;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL single_grant: got %b want %b", o, e);
      end else $display("single_grant ok %b", o);
      for (int k = 0; k < 3; k++) begin
         i0 = pat[k];
         step();
         if (k == 2) req0 = 1'b0;
         o = {gnt0, gnt1, s, busy, y_valid, y};
         e = {5'b10011, pat[k]};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL single_beat%0d: got %b want %b", k, o, e);
         end else $display("single_beat%0d ok %b", k, o);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         o = {gnt0, gnt1, s, busy, y_valid, y};
         e = 6'b000001;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL single_idle%0d: got %b want %b", k, o, e);
         end else $display("single_idle%0d ok %b", k, o);
      end
   endtask

   task automatic test_contention();
      logic [5:0] o, e;
      logic g1e, yve, ye;
      pulse_reset();
      req0 = 1'b1; req1 = 1'b1; i0 = 1'b1; i1 = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         step();
         g1e = (((c - 1) / 4) % 2) == 1;
         yve = (c >= 2);
         ye  = (c >= 2) && ((((c - 2) / 4) % 2) == 0);
         e = {~g1e, g1e, g1e, 1'b1, yve, ye};
         o = {gnt0, gnt1, s, busy, y_valid, y};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL contention_c%0d: got %b want %b", c, o, e);
         end else $display("contention_c%0d ok %b", c, o);
      end
   endtask

   task automatic test_handover();
      logic [5:0] o;
      logic [5:0] exp_tab [3];
      exp_tab[0] = 6'b100100;   // switched straight to G0, release cycle has no beat
      exp_tab[1] = 6'b100111;   // first channel-0 beat
      exp_tab[2] = 6'b000001;   // released to IDLE
      req1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 1) req0 = 1'b0;
         o = {gnt0, gnt1, s, busy, y_valid, y};
         n_cmp++;
         if (o !== exp_tab[k]) begin
            n_err++;
            $display("FAIL handover%0d: got %b want %b", k, o, exp_tab[k]);
         end else $display("handover%0d ok %b", k, o);
      end
   endtask

   task automatic test_saturation();
      logic [5:0] o, e;
      pulse_reset();
      req0 = 1'b0; req1 = 1'b1; i0 = 1'b0; i1 = 1'b1;
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b011100;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL sat_grant: got %b want %b", o, e);
      end else $display("sat_grant ok %b", o);
      for (int k = 1; k <= 10; k++) begin
         step();
         o = {gnt0, gnt1, s, busy, y_valid, y};
         e = 6'b011111;
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL sat_beat%0d: got %b want %b", k, o, e);
         end else $display("sat_beat%0d ok %b", k, o);
      end
      req0 = 1'b1;
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b100111;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL sat_switch: got %b want %b", o, e);
      end else $display("sat_switch ok %b", o);
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b100110;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL sat_ch0_beat: got %b want %b", o, e);
      end else $display("sat_ch0_beat ok %b", o);
   endtask

   task automatic test_async_reset();
      logic [5:0] o, e;
      i0 = 1'b1;
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b100111;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL areset_pre: got %b want %b", o, e);
      end else $display("areset_pre ok %b", o);
      rst_n = 1'b0;
      #2;
      o = {gnt0, gnt1, s, busy, y_valid, y};
      n_cmp++;
      if (o !== 6'b000000) begin
         n_err++;
         $display("FAIL areset_immediate: got %b want %b", o, 6'b000000);
      end else $display("areset_immediate ok %b", o);
      step();
      rst_n = 1'b1;
      step();
      o = {gnt0, gnt1, s, busy, y_valid, y};
      e = 6'b100100;
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL areset_ch0_first: got %b want %b", o, e);
      end else $display("areset_ch0_first ok %b", o);
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_width8();
      logic [12:0] o, e;
      logic        g1e;
      r80 = 1'b1; r81 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
      rst8_n = 1'b1;
      step();
      o = {g80, g81, s8, busy8, yv8, y8};
      e = {5'b10010, 8'h00};
      n_cmp++;
      if (o !== e) begin
         n_err++;
         $display("FAIL w8_grant: got %h want %h", o, e);
      end else $display("w8_grant ok %h", o);
      for (int c = 2; c <= 9; c++) begin
         step();
         g1e = (c % 2) == 0;
         e = {~g1e, g1e, g1e, 1'b1, 1'b1, (g1e ? 8'hA5 : 8'h3C)};
         o = {g80, g81, s8, busy8, yv8, y8};
         n_cmp++;
         if (o !== e) begin
            n_err++;
            $display("FAIL w8_alt_c%0d: got %h want %h", c, o, e);
         end else $display("w8_alt_c%0d ok %h", c, o);
      end
   endtask

   initial begin
      rst8_n = 1'b0; r80 = 1'b0; r81 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      test_reset();
      test_single();
      test_contention();
      test_handover();
      test_saturation();
      test_async_reset();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
